// File: rtl/lbp_scan_ctrl_pkg.sv
// Shared types and constants for the LBP scan controller.
package lbp_pkg;

  localparam int unsigned IMG_W_DEF = 128;
  localparam int unsigned CW_DEF    = 7;

  localparam logic [3:0] INIT_LAST = 4'd9;
  localparam logic [3:0] FILL_LAST = 4'd2;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StCalc,
    StMove,
    StFill,
    StTail,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    DirRight,
    DirLeft,
    DirDown
  } dir_e;

endpackage

// File: rtl/lbp_scan_ctrl_if.sv
// Control bundle between the scan sequencer and the gray-address calculator/host.
interface lbp_scan_ctrl_if #(
  parameter int unsigned CW = 7
);
  logic          gray_ready;
  logic          gray_req;
  logic          initialize;
  logic          fill_right;
  logic          fill_left;
  logic          fill_down;
  logic          gray_addr_en;
  logic [3:0]    cycle;
  logic [2*CW-1:0] lbp_addr;
  logic          gdata_vld;
  logic          lbp_valid;
  logic          finish;

  modport master (
    input  gray_ready,
    output gray_req, initialize, fill_right, fill_left, fill_down, gray_addr_en,
    output cycle, lbp_addr, gdata_vld, lbp_valid, finish
  );

  modport slave (
    output gray_ready,
    input  gray_req, initialize, fill_right, fill_left, fill_down, gray_addr_en,
    input  cycle, lbp_addr, gdata_vld, lbp_valid, finish
  );
endinterface

// File: rtl/lbp_scan_ctrl.sv
// Serpentine 3x3-window scan sequencer for the LBP datapath; all outputs registered.
module lbp_scan_ctrl
  import lbp_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  lbp_scan_ctrl_if.master bus
);

  localparam logic [CW-1:0] EdgeHi = CW'(IMG_W - 2);
  localparam logic [CW-1:0] EdgeLo = CW'(1);

  state_e      state;
  dir_e        dir;
  logic [CW-1:0] row, col;
  logic [3:0]  cyc;

  assign bus.cycle    = cyc;
  assign bus.lbp_addr = {row, col};

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= StIdle;
      dir              <= DirRight;
      row              <= '0;
      col              <= '0;
      cyc              <= '0;
      bus.gray_req     <= 1'b0;
      bus.initialize   <= 1'b0;
      bus.fill_right   <= 1'b0;
      bus.fill_left    <= 1'b0;
      bus.fill_down    <= 1'b0;
      bus.gray_addr_en <= 1'b0;
      bus.gdata_vld    <= 1'b0;
      bus.lbp_valid    <= 1'b0;
      bus.finish       <= 1'b0;
    end else begin
      bus.initialize   <= 1'b0;
      bus.fill_right   <= 1'b0;
      bus.fill_left    <= 1'b0;
      bus.fill_down    <= 1'b0;
      bus.gray_addr_en <= 1'b0;
      bus.gdata_vld    <= 1'b0;
      bus.lbp_valid    <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.gray_ready) begin
            state          <= StInit;
            row            <= EdgeLo;
            col            <= EdgeLo;
            cyc            <= 4'd1;
            bus.gray_req   <= 1'b1;
            bus.initialize <= 1'b1;
            bus.gdata_vld  <= 1'b1;
          end
        end
        StInit: begin
          if (cyc == INIT_LAST) begin
            state         <= StCalc;
            cyc           <= '0;
            bus.lbp_valid <= 1'b1;
          end else begin
            cyc            <= cyc + 4'd1;
            bus.initialize <= 1'b1;
            bus.gdata_vld  <= 1'b1;
          end
        end
        StCalc: begin
          if (row == EdgeHi && col == EdgeLo) begin
            state        <= StDone;
            bus.gray_req <= 1'b0;
            bus.finish   <= 1'b1;
          end else begin
            // New centre is visible from MOVE onwards; direction held through FILL.
            state <= StMove;
            if (row[0]) begin
              if (col < EdgeHi) begin
                col <= col + 1'b1;
                dir <= DirRight;
              end else begin
                row <= row + 1'b1;
                dir <= DirDown;
              end
            end else begin
              if (col > EdgeLo) begin
                col <= col - 1'b1;
                dir <= DirLeft;
              end else begin
                row <= row + 1'b1;
                dir <= DirDown;
              end
            end
          end
        end
        StMove: begin
          state            <= StFill;
          cyc              <= '0;
          bus.gray_addr_en <= 1'b1;
          bus.fill_right   <= (dir == DirRight);
          bus.fill_left    <= (dir == DirLeft);
          bus.fill_down    <= (dir == DirDown);
        end
        StFill: begin
          // Calculator registers the address, so data is valid one clock behind.
          bus.gdata_vld <= 1'b1;
          if (cyc == FILL_LAST) begin
            state <= StTail;
            cyc   <= '0;
          end else begin
            cyc              <= cyc + 4'd1;
            bus.gray_addr_en <= 1'b1;
            bus.fill_right   <= (dir == DirRight);
            bus.fill_left    <= (dir == DirLeft);
            bus.fill_down    <= (dir == DirDown);
          end
        end
        StTail: begin
          state         <= StCalc;
          bus.lbp_valid <= 1'b1;
        end
        StDone: begin
          state <= StDone;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
